// File: rtl/npu_seq_ctrl.sv
// Row-by-row Q8.8 matrix-vector sequencer: fetch, accumulate, rescale, clamp/wrap, ReLU, write.
// Define NPU_SEQ_SAT_EN to saturate row results; otherwise they wrap to DATA_WIDTH bits.
module npu_seq_ctrl #(
  parameter int unsigned MATRIX_SIZE = 8,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ACC_WIDTH   = 40
) (
  input  logic                                        aclk,
  input  logic                                        areset,
  input  logic                                        soft_rst,
  input  logic                                        start,
  input  logic [3:0]                                  cfg_size,
  input  logic                                        cfg_relu,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        err_start,
  output logic                                        w_rd_en,
  output logic [$clog2(MATRIX_SIZE*MATRIX_SIZE)-1:0]  w_rd_addr,
  input  logic [DATA_WIDTH-1:0]                       w_rd_data,
  output logic                                        x_rd_en,
  output logic [$clog2(MATRIX_SIZE)-1:0]              x_rd_addr,
  input  logic [DATA_WIDTH-1:0]                       x_rd_data,
  output logic                                        y_wr_en,
  output logic [$clog2(MATRIX_SIZE)-1:0]              y_wr_addr,
  output logic [DATA_WIDTH-1:0]                       y_wr_data,
  output logic [15:0]                                 cycle_cnt
);

  localparam int unsigned IW = $clog2(MATRIX_SIZE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LAST  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                        r_state;
  state_t                        w_next;
  logic [IW:0]                   r_n;
  logic                          r_relu;
  logic [IW-1:0]                 r_row;
  logic [IW-1:0]                 r_col;
  logic signed [ACC_WIDTH-1:0]   r_acc;
  logic [15:0]                   r_cnt;
  logic                          r_err;
  logic                          r_y_en;
  logic [IW-1:0]                 r_y_addr;
  logic [DATA_WIDTH-1:0]         r_y_data;

  logic [IW:0]                   w_n_cfg;
  logic [IW-1:0]                 w_n_last;
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0]   w_acc_sum;
  logic [DATA_WIDTH-1:0]         w_sat;
  logic [DATA_WIDTH-1:0]         w_res;

  always_comb begin
    w_n_cfg = (IW+1)'(cfg_size);
    if (cfg_size == '0 || 32'(cfg_size) > MATRIX_SIZE)
      w_n_cfg = (IW+1)'(MATRIX_SIZE);
  end

  assign w_n_last  = IW'(r_n - 1'b1);
  assign w_prod    = $signed(w_rd_data) * $signed(x_rd_data);
  assign w_acc_sum = r_acc + {{(ACC_WIDTH-2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};

  // Result bits are acc[DATA_WIDTH+7:8]; everything above them must be pure sign to fit.
  always_comb begin
    w_sat = w_acc_sum[DATA_WIDTH+7:8];
`ifdef NPU_SEQ_SAT_EN
    if (!(w_acc_sum[ACC_WIDTH-1:DATA_WIDTH+7] == '0 ||
          w_acc_sum[ACC_WIDTH-1:DATA_WIDTH+7] == '1))
      w_sat = w_acc_sum[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                     : {1'b0, {(DATA_WIDTH-1){1'b1}}};
`endif
    w_res = (r_relu && w_sat[DATA_WIDTH-1]) ? '0 : w_sat;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_FETCH;
      S_FETCH: if (r_col == w_n_last) w_next = S_LAST;
      S_LAST:  w_next = S_WRITE;
      S_WRITE: w_next = (r_row == w_n_last) ? S_DONE : S_FETCH;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (soft_rst) w_next = S_IDLE;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state  <= S_IDLE;
      r_n      <= '0;
      r_relu   <= 1'b0;
      r_row    <= '0;
      r_col    <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_y_en   <= 1'b0;
      r_y_addr <= '0;
      r_y_data <= '0;
    end else begin
      r_state <= w_next;
      r_err   <= 1'b0;
      r_y_en  <= 1'b0;
      if (soft_rst) begin
        r_acc <= '0;
      end else begin
        if (start && r_state != S_IDLE) r_err <= 1'b1;
        if (r_state != S_IDLE && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
        case (r_state)
          S_IDLE: if (start) begin
            r_n    <= w_n_cfg;
            r_relu <= cfg_relu;
            r_row  <= '0;
            r_col  <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
          end
          // Read data lags the address by one cycle, so col 0 has nothing to add yet.
          S_FETCH: begin
            if (r_col != '0) r_acc <= w_acc_sum;
            if (r_col != w_n_last) r_col <= r_col + 1'b1;
          end
          S_LAST: begin
            r_acc    <= w_acc_sum;
            r_y_en   <= 1'b1;
            r_y_addr <= r_row;
            r_y_data <= w_res;
          end
          S_WRITE: begin
            r_acc <= '0;
            r_col <= '0;
            if (r_row != w_n_last) r_row <= r_row + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy      = (r_state == S_FETCH) || (r_state == S_LAST) || (r_state == S_WRITE);
  assign done      = (r_state == S_DONE);
  assign err_start = r_err;
  assign w_rd_en   = (r_state == S_FETCH);
  assign x_rd_en   = (r_state == S_FETCH);
  assign w_rd_addr = {r_row, r_col};
  assign x_rd_addr = r_col;
  assign y_wr_en   = r_y_en;
  assign y_wr_addr = r_y_addr;
  assign y_wr_data = r_y_data;
  assign cycle_cnt = r_cnt;

endmodule

// File: tb/tb_npu_seq_ctrl.sv
// Bench for npu_seq_ctrl: job-timeline model checked every cycle plus directed literal checks.
module tb_npu_seq_ctrl;

  logic        aclk;
  logic        areset;
  logic        soft_rst;
  logic        start;
  logic [3:0]  cfg_size;
  logic        cfg_relu;
  logic        busy;
  logic        done;
  logic        err_start;
  logic        w_rd_en;
  logic [5:0]  w_rd_addr;
  logic [15:0] w_rd_data;
  logic        x_rd_en;
  logic [2:0]  x_rd_addr;
  logic [15:0] x_rd_data;
  logic        y_wr_en;
  logic [2:0]  y_wr_addr;
  logic [15:0] y_wr_data;
  logic [15:0] cycle_cnt;

  npu_seq_ctrl #(.MATRIX_SIZE(8), .DATA_WIDTH(16), .ACC_WIDTH(40)) dut (
    .aclk(aclk), .areset(areset), .soft_rst(soft_rst), .start(start),
    .cfg_size(cfg_size), .cfg_relu(cfg_relu),
    .busy(busy), .done(done), .err_start(err_start),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
    .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr), .x_rd_data(x_rd_data),
    .y_wr_en(y_wr_en), .y_wr_addr(y_wr_addr), .y_wr_data(y_wr_data),
    .cycle_cnt(cycle_cnt)
  );

`ifdef NPU_SEQ_SAT_EN
  localparam logic [15:0] SAT_EXP = 16'h7FFF;
`else
  localparam logic [15:0] SAT_EXP = 16'h0800;
`endif

  int n_total = 0;
  int n_bad   = 0;

  logic [15:0] wmem [64];
  logic [15:0] xmem [8];
  logic [15:0] y_got [8];
  int n_writes, n_done, n_err;

  // model state
  bit          m_job = 0;
  int          m_k = 0;
  int          m_n = 8;
  bit          m_relu = 0;
  logic [15:0] m_cnt = '0;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    if (w_rd_en) w_rd_data <= wmem[w_rd_addr];
    if (x_rd_en) x_rd_data <= xmem[x_rd_addr];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_y(input int row, input int n, input bit relu);
    longint acc = 0;
    longint r;
    logic [15:0] res;
    for (int c = 0; c < n; c++)
      acc += longint'($signed(wmem[row*8+c])) * longint'($signed(xmem[c]));
    r = acc >>> 8;
`ifdef NPU_SEQ_SAT_EN
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`endif
    res = r[15:0];
    if (relu && res[15]) res = '0;
    return res;
  endfunction

  // Each job is a timeline: cycles 1..n(n+2) are rows of (n reads, 1 gap, 1 write), then done.
  task automatic step();
    bit s, sr, was_busy;
    bit e_busy, e_done, e_rd, e_y, e_err;
    int per, row, pos;
    s = start; sr = soft_rst; was_busy = m_job;
    e_err = 0;
    if (areset) begin
      m_job = 0; m_cnt = '0;
    end else begin
      if (was_busy && !sr && m_cnt != 16'hFFFF) m_cnt++;
      if (m_job) begin
        m_k++;
        if (m_k > m_n*(m_n+2)+1) m_job = 0;
      end
      if (sr) m_job = 0;
      e_err = s && was_busy && !sr;
      if (s && !was_busy && !sr) begin
        m_job = 1; m_k = 1; m_cnt = '0; m_relu = cfg_relu;
        m_n = (cfg_size == 0 || cfg_size > 8) ? 8 : int'(cfg_size);
      end
    end
    e_busy = 0; e_done = 0; e_rd = 0; e_y = 0; row = 0; pos = 0;
    if (m_job) begin
      per = m_n + 2;
      if (m_k <= m_n*per) begin
        row = (m_k-1) / per; pos = (m_k-1) % per;
        e_busy = 1; e_rd = (pos < m_n); e_y = (pos == m_n+1);
      end else e_done = 1;
    end
    chk("busy", 64'(busy), 64'(e_busy));
    chk("done", 64'(done), 64'(e_done));
    chk("err_start", 64'(err_start), 64'(e_err));
    chk("w_rd_en", 64'(w_rd_en), 64'(e_rd));
    chk("x_rd_en", 64'(x_rd_en), 64'(e_rd));
    chk("y_wr_en", 64'(y_wr_en), 64'(e_y));
    chk("cycle_cnt", 64'(cycle_cnt), 64'(m_cnt));
    if (e_rd) begin
      chk("w_rd_addr", 64'(w_rd_addr), 64'(row*8+pos));
      chk("x_rd_addr", 64'(x_rd_addr), 64'(pos));
    end
    if (e_y) begin
      chk("y_wr_addr", 64'(y_wr_addr), 64'(row));
      chk("y_wr_data", 64'(y_wr_data), 64'(exp_y(row, m_n, m_relu)));
    end
    if (areset) begin
      chk("rst_w_addr", 64'(w_rd_addr), 64'(0));
      chk("rst_y_data", 64'(y_wr_data), 64'(0));
    end
    if (y_wr_en) begin y_got[y_wr_addr] = y_wr_data; n_writes++; end
    if (done) n_done++;
    if (err_start) n_err++;
  endtask

  always @(posedge aclk) begin
    #2;
    step();
  end

  task automatic tick();
    @(posedge aclk);
    #3;
  endtask

  task automatic kick(input logic [3:0] sz, input bit relu);
    cfg_size = sz; cfg_relu = relu;
    n_writes = 0; n_done = 0; n_err = 0;
    for (int i = 0; i < 8; i++) y_got[i] = 16'hDEAD;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int from, output int c);
    c = from;
    while (!done && c < 400) begin tick(); c++; end
    if (!done) chk("done_timeout", 64'(done), 64'(1));
  endtask

  task automatic load_identity();
    for (int i = 0; i < 64; i++) wmem[i] = (i/8 == i%8) ? 16'h0100 : 16'h0000;
    for (int i = 0; i < 8; i++) xmem[i] = 16'h0100;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c;
    areset = 1'b1; soft_rst = 1'b0; start = 1'b0; cfg_size = 4'd8; cfg_relu = 1'b0;
    load_identity();
    repeat (3) @(posedge aclk);
    #3;
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_wen", 64'(w_rd_en), 64'(0));
    chk("reset_yen", 64'(y_wr_en), 64'(0));
    chk("reset_cnt", 64'(cycle_cnt), 64'(0));
    areset = 1'b0;
    tick();

    // identity x ones
    kick(4'd8, 1'b0);
    wait_done(1, c);
    chk("ident_done_cycle", 64'(c), 64'(81));
    tick();
    chk("ident_cycle_cnt", 64'(cycle_cnt), 64'(81));
    chk("ident_writes", 64'(n_writes), 64'(8));
    for (int i = 0; i < 8; i++) chk("ident_y", 64'(y_got[i]), 64'(16'h0100));

    // ReLU, with config changed mid-job
    for (int i = 0; i < 8; i++) wmem[i] = 16'hFF00;
    kick(4'd8, 1'b1);
    cfg_relu = 1'b0; cfg_size = 4'd3;
    wait_done(1, c);
    chk("relu_done_cycle", 64'(c), 64'(81));
    tick();
    chk("relu_on_y0", 64'(y_got[0]), 64'(16'h0000));
    chk("relu_on_y1", 64'(y_got[1]), 64'(16'h0100));
    kick(4'd8, 1'b0);
    wait_done(1, c);
    tick();
    chk("relu_off_y0", 64'(y_got[0]), 64'(16'hF800));

    // saturation / wrap, size 0 meaning full N
    for (int i = 0; i < 64; i++) wmem[i] = 16'h7F00;
    for (int i = 0; i < 8; i++) xmem[i] = 16'h7F00;
    kick(4'd0, 1'b0);
    wait_done(1, c);
    chk("sat_done_cycle", 64'(c), 64'(81));
    tick();
    chk("sat_y0", 64'(y_got[0]), 64'(SAT_EXP));
    chk("sat_y7", 64'(y_got[7]), 64'(SAT_EXP));
    load_identity();

    // reduced size
    kick(4'd4, 1'b0);
    wait_done(1, c);
    chk("n4_done_cycle", 64'(c), 64'(25));
    tick();
    chk("n4_cycle_cnt", 64'(cycle_cnt), 64'(25));
    chk("n4_writes", 64'(n_writes), 64'(4));
    chk("n4_y3", 64'(y_got[3]), 64'(16'h0100));
    chk("n4_y4_untouched", 64'(y_got[4]), 64'(16'hDEAD));

    // oversize maps to N
    kick(4'd12, 1'b0);
    wait_done(1, c);
    chk("n12_done_cycle", 64'(c), 64'(81));
    tick();

    // start while busy
    kick(4'd8, 1'b0);
    c = 1;
    while (c < 10) begin tick(); c++; end
    start = 1'b1;
    tick(); c++;
    start = 1'b0;
    wait_done(c, c);
    chk("busy_start_done_cycle", 64'(c), 64'(81));
    repeat (5) tick();
    chk("busy_start_err_pulses", 64'(n_err), 64'(1));
    chk("busy_start_dones", 64'(n_done), 64'(1));
    chk("busy_start_writes", 64'(n_writes), 64'(8));

    // soft reset in cycle 30
    kick(4'd8, 1'b0);
    c = 1;
    while (c < 30) begin tick(); c++; end
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    chk("srst_busy", 64'(busy), 64'(0));
    chk("srst_cnt_hold", 64'(cycle_cnt), 64'(29));
    repeat (100) tick();
    chk("srst_no_done", 64'(n_done), 64'(0));
    chk("srst_writes", 64'(n_writes), 64'(3));
    chk("srst_cnt_after", 64'(cycle_cnt), 64'(29));

    // async reset mid-job, then a clean job
    kick(4'd8, 1'b0);
    c = 1;
    while (c < 15) begin tick(); c++; end
    areset = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_wen", 64'(w_rd_en), 64'(0));
    chk("arst_waddr", 64'(w_rd_addr), 64'(0));
    chk("arst_cnt", 64'(cycle_cnt), 64'(0));
    tick(); tick();
    areset = 1'b0;
    tick();
    kick(4'd8, 1'b0);
    wait_done(1, c);
    chk("post_arst_done_cycle", 64'(c), 64'(81));
    tick();
    chk("post_arst_writes", 64'(n_writes), 64'(8));
    for (int i = 0; i < 8; i++) chk("post_arst_y", 64'(y_got[i]), 64'(16'h0100));

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
